// File: rtl/keyboard_pkg.sv
// keyboard_pkg: PS/2 scancode constants and key decoder state encoding
package keyboard_pkg;
  localparam logic [7:0] SC_A         = 8'h1C;
  localparam logic [7:0] SC_D         = 8'h23;
  localparam logic [7:0] SC_SPACE     = 8'h29;
  localparam logic [7:0] SC_EXT_LEFT  = 8'h6B;
  localparam logic [7:0] SC_EXT_RIGHT = 8'h74;
  localparam logic [7:0] SC_E0        = 8'hE0;
  localparam logic [7:0] SC_F0        = 8'hF0;
  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} dec_state_t;
endpackage

// File: rtl/keyboard_key_decoder.sv
// keyboard_key_decoder: PS/2 scancodes to held key levels and make pulses; KEY_REPEAT_FILTER_EN suppresses typematic repeat pulses
module keyboard_key_decoder
  import keyboard_pkg::*;
#(
  parameter logic [19:0] TIMEOUT_CYC = 20'd500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] scancode_data,
  input  logic       scancode_valid,
  output logic       keyboardAPressed,
  output logic       keyboardDPressed,
  output logic       keyboardFirePressed,
  output logic       left_make,
  output logic       right_make,
  output logic       fire_make,
  output logic       decode_error
);
  dec_state_t  state, state_nx;
  logic [19:0] cnt, cnt_nx;
  logic [4:0]  held, held_nx, hit, pulse;
  logic        err_nx, is_pfx, ext, brk, fin;
  // held/hit/pulse bit order: {ext_right, ext_left, space, d, a}
  always_comb begin
    ext      = state == EXT || state == EXT_BRK;
    brk      = state == BRK || state == EXT_BRK;
    is_pfx   = scancode_data == SC_E0 || scancode_data == SC_F0;
    fin      = scancode_valid && !is_pfx;
    hit      = {ext && scancode_data == SC_EXT_RIGHT, ext && scancode_data == SC_EXT_LEFT,
                !ext && scancode_data == SC_SPACE, !ext && scancode_data == SC_D,
                !ext && scancode_data == SC_A};
    held_nx  = !fin ? held : brk ? held & ~hit : held | hit;
`ifdef KEY_REPEAT_FILTER_EN
    pulse    = fin && !brk ? hit & ~held : '0;
`else
    pulse    = fin && !brk ? hit : '0;
`endif
    state_nx = state;
    cnt_nx   = '0;
    err_nx   = 1'b0;
    if (scancode_valid) begin
      state_nx = brk || !is_pfx ? IDLE : scancode_data == SC_F0 ? (ext ? EXT_BRK : BRK) : EXT;
      err_nx   = brk && is_pfx;
    end else if (state != IDLE) begin
      err_nx   = cnt == TIMEOUT_CYC - 20'd1;
      state_nx = err_nx ? IDLE : state;
      cnt_nx   = err_nx ? '0 : cnt + 20'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      held         <= '0;
      left_make    <= 1'b0;
      right_make   <= 1'b0;
      fire_make    <= 1'b0;
      decode_error <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      held         <= held_nx;
      left_make    <= pulse[0] | pulse[3];
      right_make   <= pulse[1] | pulse[4];
      fire_make    <= pulse[2];
      decode_error <= err_nx;
    end
  end
  assign keyboardAPressed    = held[0] | held[3];
  assign keyboardDPressed    = held[1] | held[4];
  assign keyboardFirePressed = held[2];
endmodule

// File: tb/tb_keyboard_key_decoder.sv
// tb_keyboard_key_decoder: directed vector table plus randomized bytes checked against a behavioural model
module tb_keyboard_key_decoder;
  localparam logic [19:0] TO = 20'd16;
  logic clk = 1'b0;
  logic reset, scancode_valid;
  logic [7:0] scancode_data;
  logic a_p, d_p, f_p, lm, rm, fm, err;
  logic [6:0] dut_out;
  always #5 clk = ~clk;
  keyboard_key_decoder #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .scancode_data(scancode_data), .scancode_valid(scancode_valid),
    .keyboardAPressed(a_p), .keyboardDPressed(d_p), .keyboardFirePressed(f_p),
    .left_make(lm), .right_make(rm), .fire_make(fm), .decode_error(err)
  );
  // packed as {error, fire_make, right_make, left_make, fire, right, left}
  assign dut_out = {err, fm, rm, lm, f_p, d_p, a_p};
  typedef struct {logic r; logic v; logic [7:0] d; logic [6:0] e;} vec_t;
  vec_t tbl[$];
  int compared = 0, mismatched = 0;
`ifdef KEY_REPEAT_FILTER_EN
  localparam logic [6:0] D_REP = 7'b0000010;
`else
  localparam logic [6:0] D_REP = 7'b0010010;
`endif
  // model: pending prefix flags, idle cycles since last byte, per-source held keys
  // source index: 0 A, 1 D, 2 space, 3 ext-left, 4 ext-right
  bit m_ext, m_brk, m_err;
  int m_idle;
  bit [4:0] m_held, m_pulse;
  function automatic int src_of(bit e, logic [7:0] d);
    if (e) return d == 8'h6B ? 3 : d == 8'h74 ? 4 : -1;
    return d == 8'h1C ? 0 : d == 8'h23 ? 1 : d == 8'h29 ? 2 : -1;
  endfunction
  function automatic void model(logic r, logic v, logic [7:0] d);
    int s;
    m_pulse = '0;
    m_err = 0;
    if (r) begin
      m_ext = 0; m_brk = 0; m_idle = 0; m_held = '0;
      return;
    end
    if (v) begin
      m_idle = 0;
      if (d == 8'hE0 || d == 8'hF0) begin
        if (m_brk) begin m_err = 1; m_ext = 0; m_brk = 0; end
        else if (d == 8'hE0) m_ext = 1;
        else m_brk = 1;
      end else begin
        s = src_of(m_ext, d);
        if (s >= 0) begin
          if (m_brk) m_held[s] = 0;
          else begin
`ifdef KEY_REPEAT_FILTER_EN
            m_pulse[s] = !m_held[s];
`else
            m_pulse[s] = 1;
`endif
            m_held[s] = 1;
          end
        end
        m_ext = 0; m_brk = 0;
      end
    end else if (m_ext || m_brk) begin
      m_idle++;
      if (m_idle == int'(TO)) begin m_err = 1; m_ext = 0; m_brk = 0; m_idle = 0; end
    end
  endfunction
  function automatic logic [6:0] model_out();
    return {m_err, m_pulse[2], m_pulse[1] | m_pulse[4], m_pulse[0] | m_pulse[3],
            m_held[2], m_held[1] | m_held[4], m_held[0] | m_held[3]};
  endfunction
  function automatic void add(logic r, logic v, logic [7:0] d, logic [6:0] e);
    tbl.push_back('{r, v, d, e});
  endfunction
  task automatic tick(input logic r, input logic v, input logic [7:0] d);
    reset = r; scancode_valid = v; scancode_data = d;
    model(r, v, d);
    @(negedge clk);
  endtask
  task automatic check(input string name, input logic [6:0] exp);
    compared++;
    if (dut_out !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b expected %b (err,fm,rm,lm,fire,D,A)", name, dut_out, exp);
    end
  endtask
  initial begin
    reset = 1; scancode_valid = 0; scancode_data = 8'h00;
    @(negedge clk);
    add(1, 0, 8'h00, 7'b0000000);
    add(0, 1, 8'h1C, 7'b0001001);
    add(0, 1, 8'hF0, 7'b0000001);
    add(0, 1, 8'h1C, 7'b0000000);
    add(0, 1, 8'hE0, 7'b0000000);
    add(0, 1, 8'h6B, 7'b0001001);
    add(0, 1, 8'h1C, 7'b0001001);
    add(0, 1, 8'hF0, 7'b0000001);
    add(0, 1, 8'h1C, 7'b0000001);
    add(0, 1, 8'hE0, 7'b0000001);
    add(0, 1, 8'hF0, 7'b0000001);
    add(0, 1, 8'h6B, 7'b0000000);
    add(0, 1, 8'h23, 7'b0010010);
    add(0, 1, 8'h23, D_REP);
    add(0, 1, 8'h23, D_REP);
    add(0, 1, 8'hF0, 7'b0000010);
    add(0, 1, 8'h23, 7'b0000000);
    add(0, 1, 8'hF0, 7'b0000000);
    for (int i = 0; i < 15; i++) add(0, 0, 8'h00, 7'b0000000);
    add(0, 0, 8'h00, 7'b1000000);
    add(0, 1, 8'h29, 7'b0100100);
    add(0, 1, 8'hF0, 7'b0000100);
    add(0, 1, 8'hF0, 7'b1000100);
    add(0, 1, 8'h1C, 7'b0001101);
    add(0, 1, 8'h23, 7'b0010111);
    add(0, 1, 8'hE0, 7'b0000111);
    add(1, 1, 8'h1C, 7'b0000000);
    add(0, 0, 8'h00, 7'b0000000);
    add(0, 1, 8'hF0, 7'b0000000);
    add(0, 1, 8'h1C, 7'b0000000);
    add(0, 0, 8'h00, 7'b0000000);
    foreach (tbl[i]) begin
      tick(tbl[i].r, tbl[i].v, tbl[i].d);
      check($sformatf("vec%0d", i), tbl[i].e);
    end
    for (int i = 0; i < 4000; i++) begin
      logic v, r;
      logic [7:0] d;
      v = (i / 400) % 2 == 0 ? $urandom_range(0, 1) == 0 : $urandom_range(0, 11) == 0;
      r = $urandom_range(0, 299) == 0;
      case ($urandom_range(0, 9))
        0, 1: d = 8'hE0;
        2, 3: d = 8'hF0;
        4: d = 8'h1C;
        5: d = 8'h23;
        6: d = 8'h29;
        7: d = 8'h6B;
        8: d = 8'h74;
        default: d = 8'($urandom);
      endcase
      tick(r, v, d);
      check($sformatf("rand%0d", i), model_out());
    end
    scancode_valid = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
